// File: rtl/p405s_icu_defs_pkg.sv
// Shared ICU constants: valid-array write FSM encodings, flash default, write payload.
package p405s_icu_defs_pkg;

    localparam int unsigned IDX_W            = 3;
    localparam int unsigned FLASH_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        VA_IDLE  = 2'd0,
        VA_WRITE = 2'd1,
        VA_FLASH = 2'd2
    } va_wr_state_e;

    // Single-index write to the valid array.
    typedef struct packed {
        logic             cyc;
        logic [IDX_W-1:0] idx;
        logic             data;
    } va_wr_t;

endpackage

// File: rtl/p405s_icu_va_wr_arb.sv
// Combinational request selection for the valid-array writer:
// flash > invalidate > fill, with an invalidate absorbing a same-index fill.
module p405s_icu_va_wr_arb
    import p405s_icu_defs_pkg::*;
(
    input  logic             flash_req_i,
    input  logic             inv_req_i,
    input  logic [IDX_W-1:0] inv_idx_i,
    input  logic             fill_req_i,
    input  logic [IDX_W-1:0] fill_idx_i,
    output logic             sel_flash_c,
    output logic             sel_wr_c,
    output va_wr_t           wr_c,
    output logic             inv_ack_c,
    output logic             fill_ack_c
);

    // Priority pick; a fill on the line being invalidated is acked and dropped.
    always_comb begin
        sel_flash_c = 1'b0;
        sel_wr_c    = 1'b0;
        wr_c        = '0;
        inv_ack_c   = 1'b0;
        fill_ack_c  = 1'b0;
        if (flash_req_i) begin
            sel_flash_c = 1'b1;
        end else if (inv_req_i) begin
            sel_wr_c   = 1'b1;
            wr_c.cyc   = 1'b1;
            wr_c.idx   = inv_idx_i;
            wr_c.data  = 1'b0;
            inv_ack_c  = 1'b1;
            fill_ack_c = fill_req_i && (fill_idx_i == inv_idx_i);
        end else if (fill_req_i) begin
            sel_wr_c   = 1'b1;
            wr_c.cyc   = 1'b1;
            wr_c.idx   = fill_idx_i;
            wr_c.data  = 1'b1;
            fill_ack_c = 1'b1;
        end
    end

endmodule

// File: rtl/p405s_icu_va_wr_ctl.sv
// ICU valid-array write controller: serialises fill, icbi and iccci updates
// into single-index writes or a multi-cycle flash, all outputs registered.
module p405s_icu_va_wr_ctl
    import p405s_icu_defs_pkg::*;
#(
    parameter int unsigned FLASH_CYCLES = FLASH_CYCLES_DEF
) (
    input  logic       CB,
    input  logic       resetCore_N,
    input  logic       fillWrReq,
    input  logic [1:3] fillWrIdx,
    input  logic       invReq,
    input  logic [1:3] invIdx,
    input  logic       flashReq,
    input  logic       wrHold,
    output logic       vaWrCycle,
    output logic [1:3] vaWrIndex,
    output logic       vaWrData,
    output logic       wrFlash,
    output logic       fillWrAck,
    output logic       invAck,
    output logic       flashAck,
    output logic       vaWrBusy
);

    localparam int unsigned CNT_W = (FLASH_CYCLES < 1) ? 1 : $clog2(FLASH_CYCLES + 1);

    va_wr_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    va_wr_t           wr_q, wr_d;
    logic             flash_q, flash_d;
    logic             fill_ack_q, fill_ack_d;
    logic             inv_ack_q, inv_ack_d;
    logic             flash_ack_q, flash_ack_d;
    logic             busy_q, busy_d;

    logic             sel_flash_c;
    logic             sel_wr_c;
    va_wr_t           wr_c;
    logic             inv_ack_c;
    logic             fill_ack_c;

    p405s_icu_va_wr_arb u_arb (
        .flash_req_i (flashReq),
        .inv_req_i   (invReq),
        .inv_idx_i   (invIdx),
        .fill_req_i  (fillWrReq),
        .fill_idx_i  (fillWrIdx),
        .sel_flash_c (sel_flash_c),
        .sel_wr_c    (sel_wr_c),
        .wr_c        (wr_c),
        .inv_ack_c   (inv_ack_c),
        .fill_ack_c  (fill_ack_c)
    );

    // Next state and next registered outputs; cnt_q holds flash cycles left including the current one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = '0;
        flash_d     = 1'b0;
        fill_ack_d  = 1'b0;
        inv_ack_d   = 1'b0;
        flash_ack_d = 1'b0;
        case (state_q)
            VA_IDLE: begin
                if (!wrHold) begin
                    if (sel_flash_c) begin
                        state_d     = VA_FLASH;
                        cnt_d       = CNT_W'(FLASH_CYCLES);
                        flash_d     = 1'b1;
                        flash_ack_d = (FLASH_CYCLES == 32'd1);
                    end else if (sel_wr_c) begin
                        state_d    = VA_WRITE;
                        wr_d       = wr_c;
                        inv_ack_d  = inv_ack_c;
                        fill_ack_d = fill_ack_c;
                    end
                end
            end
            VA_WRITE: begin
                state_d = VA_IDLE;
            end
            VA_FLASH: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    flash_d     = 1'b1;
                    flash_ack_d = (cnt_q == CNT_W'(2));
                end else begin
                    state_d = VA_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = VA_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != VA_IDLE);
    end

    // State, counter and output registers; reset aborts any operation without ack.
    always_ff @(posedge CB or negedge resetCore_N) begin
        if (!resetCore_N) begin
            state_q     <= VA_IDLE;
            cnt_q       <= '0;
            wr_q        <= '0;
            flash_q     <= 1'b0;
            fill_ack_q  <= 1'b0;
            inv_ack_q   <= 1'b0;
            flash_ack_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            flash_q     <= flash_d;
            fill_ack_q  <= fill_ack_d;
            inv_ack_q   <= inv_ack_d;
            flash_ack_q <= flash_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign vaWrCycle = wr_q.cyc;
    assign vaWrIndex = wr_q.idx;
    assign vaWrData  = wr_q.data;
    assign wrFlash   = flash_q;
    assign fillWrAck = fill_ack_q;
    assign invAck    = inv_ack_q;
    assign flashAck  = flash_ack_q;
    assign vaWrBusy  = busy_q;

endmodule

// File: tb/tb_p405s_icu_va_wr_ctl.sv
// Bench for p405s_icu_va_wr_ctl: directed scenarios then random requesters,
// every cycle compared against a schedule-based reference model.
module tb_p405s_icu_va_wr_ctl;

    localparam int unsigned FC = 2;

    logic       CB = 1'b0;
    logic       resetCore_N = 1'b1;
    logic       fillWrReq, invReq, flashReq, wrHold;
    logic [1:3] fillWrIdx, invIdx;
    logic       vaWrCycle, vaWrData, wrFlash, fillWrAck, invAck, flashAck, vaWrBusy;
    logic [1:3] vaWrIndex;

    int errors = 0;
    int checks = 0;

    // Output vector: {vaWrCycle, vaWrIndex[3], vaWrData, wrFlash, fillWrAck, invAck, flashAck, vaWrBusy}
    logic [9:0] obs_v;
    logic [9:0] exp_v;
    logic [9:0] sched_q[$];

    assign obs_v = {vaWrCycle, vaWrIndex, vaWrData, wrFlash, fillWrAck, invAck, flashAck, vaWrBusy};

    always #5 CB = ~CB;

    p405s_icu_va_wr_ctl #(.FLASH_CYCLES(FC)) dut (
        .CB          (CB),
        .resetCore_N (resetCore_N),
        .fillWrReq   (fillWrReq),
        .fillWrIdx   (fillWrIdx),
        .invReq      (invReq),
        .invIdx      (invIdx),
        .flashReq    (flashReq),
        .wrHold      (wrHold),
        .vaWrCycle   (vaWrCycle),
        .vaWrIndex   (vaWrIndex),
        .vaWrData    (vaWrData),
        .wrFlash     (wrFlash),
        .fillWrAck   (fillWrAck),
        .invAck      (invAck),
        .flashAck    (flashAck),
        .vaWrBusy    (vaWrBusy)
    );

    function automatic logic [9:0] wr_vec(input logic [2:0] idx, input logic data,
                                          input logic fa, input logic ia);
        return {1'b1, idx, data, 1'b0, fa, ia, 1'b0, 1'b1};
    endfunction

    function automatic logic [9:0] fl_vec(input logic last);
        return {1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, last, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Reference: an accepted operation schedules its whole output sequence;
    // new requests are only looked at when nothing is scheduled.
    task automatic model_edge();
        if (!resetCore_N) begin
            sched_q.delete();
            exp_v = '0;
        end else if (sched_q.size() != 0) begin
            exp_v = sched_q.pop_front();
        end else begin
            exp_v = '0;
            if (!wrHold) begin
                if (flashReq) begin
                    for (int i = 1; i <= int'(FC); i++) sched_q.push_back(fl_vec(i == int'(FC)));
                    sched_q.push_back('0);
                end else if (invReq) begin
                    sched_q.push_back(wr_vec(invIdx, 1'b0, fillWrReq && (fillWrIdx == invIdx), 1'b1));
                    sched_q.push_back('0);
                end else if (fillWrReq) begin
                    sched_q.push_back(wr_vec(fillWrIdx, 1'b1, 1'b1, 1'b0));
                    sched_q.push_back('0);
                end
                if (sched_q.size() != 0) exp_v = sched_q.pop_front();
            end
        end
    endtask

    // One clock: model at the rising edge, compare on the falling edge, requesters drop on ack.
    task automatic tick(input string tag);
        @(posedge CB);
        model_edge();
        @(negedge CB);
        check(tag, obs_v, exp_v);
        checks++;
        assert (!(vaWrCycle && wrFlash)) else begin
            errors++;
            $error("FAIL excl_%s observed vaWrCycle=%b wrFlash=%b expected not both 1", tag, vaWrCycle, wrFlash);
        end
        if (exp_v[3]) fillWrReq = 1'b0;
        if (exp_v[2]) invReq    = 1'b0;
        if (exp_v[1]) flashReq  = 1'b0;
    endtask

    initial begin
        fillWrReq = 1'b0; invReq = 1'b0; flashReq = 1'b0; wrHold = 1'b0;
        fillWrIdx = 3'd0; invIdx = 3'd0;
        #2 resetCore_N = 1'b0;
        tick("reset0");
        check("reset0_const", obs_v, 10'b0);
        tick("reset1");

        // Fill at idx 5 presented as reset releases: first edge arbitrates.
        fillWrReq = 1'b1; fillWrIdx = 3'd5;
        resetCore_N = 1'b1;
        tick("fill5_wr");
        check("fill5_wr_const", obs_v, 10'b1_101_1_0_1_0_0_1);
        tick("fill5_idle");
        check("fill5_idle_const", obs_v, 10'b0);
        tick("quiet");

        // Flash, inv(2), fill(6) together: flash, then inv, then fill.
        flashReq = 1'b1; invReq = 1'b1; invIdx = 3'd2; fillWrReq = 1'b1; fillWrIdx = 3'd6;
        tick("pri_fl1");   check("pri_fl1_const", obs_v, 10'b0_000_0_1_0_0_0_1);
        tick("pri_fl2");   check("pri_fl2_const", obs_v, 10'b0_000_0_1_0_0_1_1);
        tick("pri_gap0");  check("pri_gap0_const", obs_v, 10'b0);
        tick("pri_inv");   check("pri_inv_const", obs_v, 10'b1_010_0_0_0_1_0_1);
        tick("pri_gap1");  check("pri_gap1_const", obs_v, 10'b0);
        tick("pri_fill");  check("pri_fill_const", obs_v, 10'b1_110_1_0_1_0_0_1);
        tick("pri_gap2");  check("pri_gap2_const", obs_v, 10'b0);

        // Same-index inv and fill merge into one invalidate with both acks.
        invReq = 1'b1; invIdx = 3'd3; fillWrReq = 1'b1; fillWrIdx = 3'd3;
        tick("merge_wr");  check("merge_wr_const", obs_v, 10'b1_011_0_0_1_1_0_1);
        tick("merge_idle"); check("merge_idle_const", obs_v, 10'b0);

        // wrHold stalls an invalidate for 4 cycles.
        wrHold = 1'b1; invReq = 1'b1; invIdx = 3'd7;
        for (int i = 0; i < 4; i++) begin
            tick("hold");
            check("hold_const", obs_v, 10'b0);
        end
        wrHold = 1'b0;
        tick("hold_rel");  check("hold_rel_const", obs_v, 10'b1_111_0_0_0_1_0_1);
        tick("hold_idle"); check("hold_idle_const", obs_v, 10'b0);

        // Reset in the first flash cycle aborts it; flash restarts after release.
        flashReq = 1'b1;
        tick("rst_fl1");   check("rst_fl1_const", obs_v, 10'b0_000_0_1_0_0_0_1);
        #2 resetCore_N = 1'b0;
        #1 check("rst_async", obs_v, 10'b0);
        sched_q.delete();
        exp_v = '0;
        tick("rst_low");
        resetCore_N = 1'b1;
        tick("rst_re1");   check("rst_re1_const", obs_v, 10'b0_000_0_1_0_0_0_1);
        tick("rst_re2");   check("rst_re2_const", obs_v, 10'b0_000_0_1_0_0_1_1);
        tick("rst_re3");   check("rst_re3_const", obs_v, 10'b0);

        // A fill withdrawn while held off produces nothing.
        wrHold = 1'b1; fillWrReq = 1'b1; fillWrIdx = 3'd4;
        tick("wd_hold");
        fillWrReq = 1'b0; wrHold = 1'b0;
        tick("wd_rel");    check("wd_rel_const", obs_v, 10'b0);
        tick("wd_idle");

        // Random requesters holding requests until ack, with occasional withdrawal.
        for (int n = 0; n < 800; n++) begin
            if (!flashReq && $urandom_range(0, 15) == 0) flashReq = 1'b1;
            else if (flashReq && $urandom_range(0, 31) == 0) flashReq = 1'b0;
            if (!invReq && $urandom_range(0, 3) == 0) begin
                invReq = 1'b1;
                invIdx = 3'($urandom_range(0, 7));
            end else if (invReq && $urandom_range(0, 31) == 0) begin
                invReq = 1'b0;
            end
            if (!fillWrReq && $urandom_range(0, 2) == 0) begin
                fillWrReq = 1'b1;
                fillWrIdx = 3'($urandom_range(0, 7));
            end else if (fillWrReq && $urandom_range(0, 31) == 0) begin
                fillWrReq = 1'b0;
            end
            wrHold = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
